// File: rtl/aes_job_sched.sv
// rtl/aes_job_sched.sv - round-robin scheduler of A/B AES jobs onto one encrypt and one decrypt core
// Optional RUN watchdog enabled by defining AES_TIMEOUT_EN.
module aes_job_sched #(
  parameter int DW      = 128,
  parameter int RST_CYC = 2
`ifdef AES_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 512
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_req_mode,
  input  logic [DW-1:0] a_req_data,
  input  logic [DW-1:0] a_req_key,
  output logic          a_rsp_valid,
  input  logic          a_rsp_ready,
  output logic [DW-1:0] a_rsp_data,
  output logic          a_rsp_err,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_req_mode,
  input  logic [DW-1:0] b_req_data,
  input  logic [DW-1:0] b_req_key,
  output logic          b_rsp_valid,
  input  logic          b_rsp_ready,
  output logic [DW-1:0] b_rsp_data,
  output logic          b_rsp_err,
  output logic          enc_rst,
  output logic [DW-1:0] enc_din,
  output logic [DW-1:0] enc_key,
  input  logic          enc_done,
  input  logic [DW-1:0] enc_ctxt,
  output logic          dec_rst,
  output logic [DW-1:0] dec_entxt,
  output logic [DW-1:0] dec_key,
  input  logic          dec_done,
  input  logic [DW-1:0] dec_ptxt,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
  localparam int LW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t        state_q, state_d;
  logic          rr_q, rr_d, owner_q, owner_d, mode_q, mode_d, first_q, first_d;
  logic [DW-1:0] data_q, data_d, key_q, key_d;
  logic [DW-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic [LW-1:0] load_q, load_d;
  logic          grant_a, grant_b, sel_done;
  logic [DW-1:0] sel_res;
`ifdef AES_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] run_q, run_d;
  logic          a_err_q, a_err_d, b_err_q, b_err_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      mode_q   <= 1'b0;
      first_q  <= 1'b0;
      data_q   <= '0;
      key_q    <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      load_q   <= '0;
`ifdef AES_TIMEOUT_EN
      run_q    <= '0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      mode_q   <= mode_d;
      first_q  <= first_d;
      data_q   <= data_d;
      key_q    <= key_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      load_q   <= load_d;
`ifdef AES_TIMEOUT_EN
      run_q    <= run_d;
      a_err_q  <= a_err_d;
      b_err_q  <= b_err_d;
`endif
    end
  end

  // rr_q: 0 favours A, 1 favours B when both requesters are valid
  assign grant_a  = a_req_valid && (!b_req_valid || !rr_q);
  assign grant_b  = b_req_valid && (!a_req_valid || rr_q);
  assign sel_done = mode_q ? dec_done : enc_done;
  assign sel_res  = mode_q ? dec_ptxt : enc_ctxt;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    mode_d      = mode_q;
    first_d     = first_q;
    data_d      = data_q;
    key_d       = key_q;
    a_data_d    = a_data_q;
    b_data_d    = b_data_q;
    load_d      = load_q;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
`ifdef AES_TIMEOUT_EN
    run_d       = run_q;
    a_err_d     = a_err_q;
    b_err_d     = b_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        a_req_ready = grant_a;
        b_req_ready = grant_b;
        if (grant_a || grant_b) begin
          owner_d = grant_b;
          mode_d  = grant_b ? b_req_mode : a_req_mode;
          data_d  = grant_b ? b_req_data : a_req_data;
          key_d   = grant_b ? b_req_key  : a_req_key;
          load_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_q == LW'(RST_CYC - 1)) begin
          first_d = 1'b1;
`ifdef AES_TIMEOUT_EN
          run_d   = '0;
`endif
          state_d = RUN;
        end else begin
          load_d = load_q + LW'(1);
        end
      end
      RUN: begin
        first_d = 1'b0;
`ifdef AES_TIMEOUT_EN
        run_d   = run_q + TW'(1);
`endif
        // done may still be stale from the previous job in the first RUN cycle
        if (!first_q && sel_done) begin
          if (owner_q) b_data_d = sel_res;
          else         a_data_d = sel_res;
`ifdef AES_TIMEOUT_EN
          if (owner_q) b_err_d = 1'b0;
          else         a_err_d = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef AES_TIMEOUT_EN
        else if (run_q == TW'(TIMEOUT_CYC - 1)) begin
          if (owner_q) begin b_data_d = '0; b_err_d = 1'b1; end
          else         begin a_data_d = '0; a_err_d = 1'b1; end
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        a_rsp_valid = !owner_q;
        b_rsp_valid = owner_q;
        if (owner_q ? b_rsp_ready : a_rsp_ready) begin
          rr_d    = !owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enc_rst    = !(state_q == RUN && !mode_q);
  assign dec_rst    = !(state_q == RUN && mode_q);
  assign enc_din    = data_q;
  assign enc_key    = key_q;
  assign dec_entxt  = data_q;
  assign dec_key    = key_q;
  assign a_rsp_data = a_data_q;
  assign b_rsp_data = b_data_q;
  assign busy       = (state_q != IDLE);
`ifdef AES_TIMEOUT_EN
  assign a_rsp_err  = a_err_q;
  assign b_rsp_err  = b_err_q;
`else
  assign a_rsp_err  = 1'b0;
  assign b_rsp_err  = 1'b0;
`endif
endmodule
